// File: rtl/tnn_operand_sequencer_if.sv
// Operand-stream and decision handshake bundle for tnn_operand_sequencer.
//   s_valid/s_ready/s_data/s_last : upstream operand beats (sequencer is sink)
//   m_valid/m_ready/m_data        : downstream 1-bit decision (sequencer is source)
// master: the upstream/downstream environment; slave: the sequencer itself.
interface tnn_operand_sequencer_if #(
  parameter int unsigned OP_W = 3
);
  logic            s_valid;
  logic            s_ready;
  logic [OP_W-1:0] s_data;
  logic            s_last;
  logic            m_valid;
  logic            m_ready;
  logic            m_data;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/tnn_operand_sequencer.sv
// Assembles a 5-beat operand frame for the ternary-neuron comparator core, holds it on
// input_a..input_e while the core settles, captures cgp_out and returns it downstream.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   bus (slave)         operand stream in, decision out (valid/ready)
//   input_a..input_e    registered operand slots driven to the core
//   cgp_out             core decision (combinational from the slots)
//   frame_cnt           decisions accepted downstream, wrapping
//   err_short/err_long  sticky frame-length errors, cleared by clr_err
module tnn_operand_sequencer #(
  parameter int unsigned OP_W        = 3,
  parameter int unsigned EVAL_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tnn_operand_sequencer_if.slave bus,
  output logic [OP_W-1:0]        input_a,
  output logic [OP_W-1:0]        input_b,
  output logic [OP_W-1:0]        input_c,
  output logic [OP_W-1:0]        input_d,
  output logic [OP_W-1:0]        input_e,
  input  logic                   cgp_out,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic                   err_short,
  output logic                   err_long,
  input  logic                   clr_err
);

  typedef enum logic [1:0] {StFill, StDrain, StEval, StOut} state_e;

  localparam logic [3:0] EvalLoad = 4'(EVAL_CYCLES);

  state_e          r_state;
  logic [2:0]      r_beat;
  logic [3:0]      r_settle;
  logic [OP_W-1:0] r_slot [5];
  logic            r_s_ready;
  logic            r_m_valid;
  logic            r_m_data;
  logic [CNT_W-1:0] r_frame_cnt;
  logic            r_err_short;
  logic            r_err_long;

  logic w_beat;
  logic w_xfer;

  assign w_beat = bus.s_valid & r_s_ready;
  assign w_xfer = r_m_valid & bus.m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StFill;
      r_beat      <= 3'd0;
      r_settle    <= 4'd0;
      for (int i = 0; i < 5; i++) r_slot[i] <= '0;
      r_s_ready   <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_data    <= 1'b0;
      r_frame_cnt <= '0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      // Clear first so that a same-cycle error set below takes priority.
      if (clr_err) begin
        r_err_short <= 1'b0;
        r_err_long  <= 1'b0;
      end
      unique case (r_state)
        StFill: begin
          r_s_ready <= 1'b1;
          if (w_beat) begin
            if (r_beat < 3'd4) begin
              if (bus.s_last) begin
                // Short frame: drop it entirely, no decision.
                r_err_short <= 1'b1;
                for (int i = 0; i < 5; i++) r_slot[i] <= '0;
                r_beat <= 3'd0;
              end else begin
                r_slot[r_beat[1:0]] <= bus.s_data;
                r_beat              <= r_beat + 3'd1;
              end
            end else begin
              r_slot[4] <= bus.s_data;
              if (bus.s_last) begin
                r_state   <= StEval;
                r_settle  <= EvalLoad;
                r_s_ready <= 1'b0;
              end else begin
                r_err_long <= 1'b1;
                r_state    <= StDrain;
              end
            end
          end
        end
        StDrain: begin
          r_s_ready <= 1'b1;
          if (w_beat && bus.s_last) begin
            r_state   <= StEval;
            r_settle  <= EvalLoad;
            r_s_ready <= 1'b0;
          end
        end
        StEval: begin
          // Frame is held EVAL_CYCLES+1 cycles before the decision is sampled.
          if (r_settle == 4'd0) begin
            r_m_data  <= cgp_out;
            r_m_valid <= 1'b1;
            r_state   <= StOut;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end
        StOut: begin
          if (w_xfer) begin
            r_m_valid   <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 1'b1;
            r_beat      <= 3'd0;
            r_state     <= StFill;
            r_s_ready   <= 1'b1;
          end
        end
        default: r_state <= StFill;
      endcase
    end
  end

  assign bus.s_ready = r_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
  assign input_a     = r_slot[0];
  assign input_b     = r_slot[1];
  assign input_c     = r_slot[2];
  assign input_d     = r_slot[3];
  assign input_e     = r_slot[4];
  assign frame_cnt   = r_frame_cnt;
  assign err_short   = r_err_short;
  assign err_long    = r_err_long;

endmodule

// File: tb/tb_tnn_operand_sequencer.sv
module tb_tnn_operand_sequencer;

  typedef struct packed {
    logic [4:0][2:0] op;  // op[0] = slot a
    logic            exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_err;
  always #5 clk = ~clk;

  tnn_operand_sequencer_if #(.OP_W(3)) bus ();
  tnn_operand_sequencer_if #(.OP_W(3)) bus2 ();

  // Second instance (CNT_W = 2) sees identical stimulus.
  assign bus2.s_valid = bus.s_valid;
  assign bus2.s_data  = bus.s_data;
  assign bus2.s_last  = bus.s_last;
  assign bus2.m_ready = bus.m_ready;

  logic [2:0]  a1, b1, c1, d1, e1, a2, b2, c2, d2, e2;
  logic        cgp1, cgp2;
  logic [15:0] fc1;
  logic [1:0]  fc2;
  logic        es1, el1, es2, el2;

  // Stand-in neuron core: fires when at least three operands are >= 4.
  function automatic logic cgp_f(input logic [2:0] a, b, c, d, e);
    int n;
    n = int'(a[2]) + int'(b[2]) + int'(c[2]) + int'(d[2]) + int'(e[2]);
    return n >= 3;
  endfunction

  assign cgp1 = cgp_f(a1, b1, c1, d1, e1);
  assign cgp2 = cgp_f(a2, b2, c2, d2, e2);

  tnn_operand_sequencer #(.OP_W(3), .EVAL_CYCLES(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .input_a(a1), .input_b(b1), .input_c(c1), .input_d(d1), .input_e(e1),
    .cgp_out(cgp1), .frame_cnt(fc1), .err_short(es1), .err_long(el1), .clr_err(clr_err)
  );

  tnn_operand_sequencer #(.OP_W(3), .EVAL_CYCLES(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .input_a(a2), .input_b(b2), .input_c(c2), .input_d(d2), .input_e(e2),
    .cgp_out(cgp2), .frame_cnt(fc2), .err_short(es2), .err_long(el2), .clr_err(clr_err)
  );

  int total = 0;
  int bad = 0;
  int xfers = 0;
  vec_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  function automatic logic [4:0][2:0] mk(input logic [2:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  // Monitor: sample mid-low-phase; a transfer happens on the following rising edge.
  logic [15:0] m16 = '0;
  logic [1:0]  m2 = '0;
  bit          pend = 0;
  always begin
    vec_t ev;
    @(negedge clk);
    #1;
    if (!rst_n) begin
      sb.delete();
      m16  = '0;
      m2   = '0;
      pend = 0;
    end else begin
      if (pend) begin
        chk("frame_cnt", 32'(fc1), 32'(m16));
        chk("frame_cnt_w2", 32'(fc2), 32'(m2));
        pend = 0;
      end
      if (bus.m_valid && bus.m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_decision", 32'(bus.m_valid), 32'd0);
        end else begin
          ev = sb.pop_front();
          chk("m_data", 32'(bus.m_data), 32'(ev.exp));
          chk("slots", 32'({e1, d1, c1, b1, a1}), 32'(ev.op));
        end
        m16 = m16 + 16'd1;
        m2  = m2 + 2'd1;
        xfers++;
        pend = 1;
      end
    end
  end

  task automatic send_beat(input logic [2:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (!bus.s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) timeout("beat_accept");
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [4:0][2:0] op, input bit push, input logic exp);
    vec_t v;
    v.op  = op;
    v.exp = exp;
    if (push) sb.push_back(v);
    for (int i = 0; i < 5; i++) send_beat(op[i], i == 4);
  endtask

  task automatic wait_mvalid();
    int n = 0;
    while (!bus.m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.m_valid) timeout("m_valid_wait");
  endtask

  task automatic wait_xfers(input int target);
    int n = 0;
    while (xfers < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (xfers < target) timeout("transfer_wait");
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl [8];

  initial begin
    int lat;
    int x0;
    tbl[0] = '{op: mk(0, 7, 7, 0, 7), exp: 1'b1};
    tbl[1] = '{op: mk(7, 0, 0, 7, 0), exp: 1'b0};
    tbl[2] = '{op: mk(7, 7, 7, 0, 0), exp: 1'b1};
    tbl[3] = '{op: mk(4, 4, 4, 3, 3), exp: 1'b1};
    tbl[4] = '{op: mk(3, 3, 3, 3, 3), exp: 1'b0};
    tbl[5] = '{op: mk(5, 1, 6, 2, 4), exp: 1'b1};
    tbl[6] = '{op: mk(1, 2, 3, 4, 5), exp: 1'b0};
    tbl[7] = '{op: mk(7, 7, 7, 7, 7), exp: 1'b1};

    bus.s_valid = 1'b0;
    bus.s_data  = 3'd0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    clr_err     = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_outputs", 32'({bus.m_valid, bus.m_data, es1, el1}), 32'd0);
    chk("rst_slots", 32'({e1, d1, c1, b1, a1}), 32'd0);
    chk("rst_frame_cnt", 32'(fc1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_rst", 32'(bus.s_ready), 32'd1);

    // Latency from 5th beat to m_valid.
    bus.m_ready = 1'b1;
    sb.push_back(tbl[0]);
    for (int i = 0; i < 4; i++) send_beat(tbl[0].op[i], 1'b0);
    send_beat(tbl[0].op[4], 1'b1);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
      end
      if (bus.m_valid) break;
    end
    chk("latency", 32'(lat), 32'd2);
    wait_xfers(1);
    repeat (2) @(negedge clk);
    chk("frame_cnt_first", 32'(fc1), 32'd1);

    // Downstream backpressure for 10 cycles.
    bus.m_ready = 1'b0;
    send_frame(tbl[1].op, 1, tbl[1].exp);
    idle();
    wait_mvalid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold", 32'({bus.m_valid, bus.m_data, bus.s_ready, e1, d1, c1, b1, a1}),
          32'({1'b1, 1'b0, 1'b0, tbl[1].op}));
    end
    x0 = xfers;
    bus.m_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("single_xfer", 32'(xfers - x0), 32'd1);
    chk("m_valid_drop", 32'(bus.m_valid), 32'd0);

    // Short frame, then a good frame.
    send_beat(3'd7, 1'b0);
    send_beat(3'd7, 1'b0);
    send_beat(3'd7, 1'b1);
    idle();
    chk("err_short", 32'(es1), 32'd1);
    chk("short_slots", 32'({e1, d1, c1, b1, a1}), 32'd0);
    repeat (4) @(negedge clk);
    chk("short_no_mvalid", 32'(bus.m_valid), 32'd0);
    x0 = xfers;
    send_frame(tbl[2].op, 1, tbl[2].exp);
    idle();
    wait_xfers(x0 + 1);

    // Long frame: 7 beats, decision from the first 5.
    x0 = xfers;
    sb.push_back(tbl[5]);
    for (int i = 0; i < 5; i++) send_beat(tbl[5].op[i], 1'b0);
    send_beat(3'd3, 1'b0);
    send_beat(3'd3, 1'b1);
    idle();
    wait_xfers(x0 + 1);
    repeat (3) @(negedge clk);
    chk("long_single_xfer", 32'(xfers - x0), 32'd1);
    chk("err_long", 32'(el1), 32'd1);
    chk("err_short_sticky", 32'(es1), 32'd1);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_err", 32'({es1, el1}), 32'd0);

    // Async reset after beat 4.
    for (int i = 0; i < 4; i++) send_beat(3'(i + 1), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_slots", 32'({e1, d1, c1, b1, a1}), 32'd0);
    chk("rst_mid_cnt", 32'(fc1), 32'd0);
    chk("rst_mid_out", 32'({bus.m_valid, bus.m_data, bus.s_ready}), 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset while in OUT.
    bus.m_ready = 1'b0;
    send_frame(mk(7, 7, 7, 7, 1), 0, 1'b1);
    idle();
    wait_mvalid();
    chk("out_before_rst", 32'(bus.m_data), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_outputs", 32'({bus.m_valid, bus.m_data, bus.s_ready}), 32'd0);
    chk("rst_out_slots", 32'({e1, d1, c1, b1, a1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    x0 = xfers;
    send_frame(tbl[3].op, 1, tbl[3].exp);
    idle();
    wait_xfers(x0 + 1);
    repeat (2) @(negedge clk);
    chk("cnt_restart", 32'(fc1), 32'd1);

    // Back-to-back table frames; narrow counter wraps 1,2,3,0,1,...
    pulse_reset();
    x0 = xfers;
    for (int i = 0; i < 8; i++) send_frame(tbl[i].op, 1, tbl[i].exp);
    idle();
    wait_xfers(x0 + 8);
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("b2b_cnt16", 32'(fc1), 32'd8);
    chk("b2b_cnt2", 32'(fc2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
